// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared PS/2 receive definitions: receive-FSM state encoding,
//               frame constants and the odd-parity check helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    // Receive FSM states; explicit 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DATA   = 2'b01,
        ST_PARITY = 2'b10,
        ST_STOP   = 2'b11
    } rx_state_t;

    localparam int   c_data_bits  = 8;
    // XOR of the data bits and the parity bit that marks a good frame.
    localparam logic c_odd_parity = 1'b1;

    function automatic logic parity_good(input logic [c_data_bits-1:0] data,
                                         input logic                   par);
        return ((^data) ^ par) == c_odd_parity;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx_fifo_if
// Description : Host-side read/status bus of the PS/2 receiver.
//   rd_en      : pop the head byte (ignored while empty)
//   clr_ovf    : clear the sticky overflow flag
//   rd_data    : head byte, show-ahead, valid while empty=0
//   empty      : no bytes held
//   count      : bytes held
//   overflow   : sticky, a good byte was dropped on a full buffer
//   parity_err : one-cycle pulse, frame dropped for bad parity
//   frame_err  : one-cycle pulse, frame dropped for bad stop bit or timeout
//   Modports: master = host side, slave = receiver side.
// Revision    : 1.0 - initial release
// ============================================================================
interface ps2_rx_fifo_if
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
);
    logic                          rd_en;
    logic                          clr_ovf;
    logic [c_data_bits-1:0]        rd_data;
    logic                          empty;
    logic [$clog2(FIFO_DEPTH):0]   count;
    logic                          overflow;
    logic                          parity_err;
    logic                          frame_err;

    modport master (
        output rd_en, clr_ovf,
        input  rd_data, empty, count, overflow, parity_err, frame_err
    );

    modport slave (
        input  rd_en, clr_ovf,
        output rd_data, empty, count, overflow, parity_err, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/ps2_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ps2_byte_fifo
// Description : Show-ahead byte FIFO with registered head output.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en      : write wr_data (dropped when full unless rd_en is also high)
//   rd_en      : pop head (ignored while empty)
//   rd_data    : head byte, valid while empty=0
//   empty/full : occupancy flags
//   count      : bytes held
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_byte_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  wire                          clk,
    input  wire                          rst_n,
    input  wire                          wr_en,
    input  wire  [c_data_bits-1:0]       wr_data,
    input  wire                          rd_en,
    output logic [c_data_bits-1:0]       rd_data,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH):0]       count
);
    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;

    logic [c_data_bits-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]        r_wr_ptr;
    logic [c_aw-1:0]        r_rd_ptr;
    logic [c_cw-1:0]        r_count;
    logic [c_data_bits-1:0] r_rd_data;

    logic                   w_do_wr;
    logic                   w_do_rd;
    logic [c_aw-1:0]        w_rd_ptr_nxt;

    assign empty        = (r_count == '0);
    assign full         = (r_count == c_cw'(DEPTH));
    assign w_do_rd      = rd_en & ~empty;
    // A full FIFO still accepts a write when a pop frees a slot in the same cycle.
    assign w_do_wr      = wr_en & (~full | rd_en);
    assign w_rd_ptr_nxt = r_rd_ptr + c_aw'(1);

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + c_aw'(1);
            if (w_do_rd) r_rd_ptr <= w_rd_ptr_nxt;

            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + c_cw'(1);
                2'b01:   r_count <= r_count - c_cw'(1);
                default: r_count <= r_count;
            endcase

            // Head register: on a pop, take the next entry; if the popped byte was
            // the last one, the only possible new head is the byte being written.
            if (w_do_rd) begin
                r_rd_data <= (r_count == c_cw'(1)) ? wr_data : r_mem[w_rd_ptr_nxt];
            end else if (empty && w_do_wr) begin
                r_rd_data <= wr_data;
            end
        end
    end

    assign rd_data = r_rd_data;
    assign count   = r_count;

endmodule
`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx_fifo
// Description : PS/2 device-to-host frame receiver with byte FIFO.
//   clk, rst_n        : system clock, asynchronous active-low reset
//   ps2_clk, ps2_data : asynchronous PS/2 lines
//   bus (slave)       : host read/status bus (see ps2_rx_fifo_if)
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int SYNC_STAGES    = 2
) (
    input  wire            clk,
    input  wire            rst_n,
    input  wire            ps2_clk,
    input  wire            ps2_data,
    ps2_rx_fifo_if.slave   bus
);
    localparam int c_cw = $clog2(FIFO_DEPTH) + 1;
    localparam int c_tw = $clog2(TIMEOUT_CYCLES + 1);
    // r_tmo reads 0 in the cycle after an edge, so firing while it reads T-2
    // makes frame_err visible exactly TIMEOUT_CYCLES cycles after the edge cycle.
    localparam logic [c_tw-1:0] c_tmo_last = c_tw'(TIMEOUT_CYCLES - 2);

    // ---------------- synchronisers and edge detect ----------------
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_clk_prev;
    logic                   w_clk_s;
    logic                   w_bit;
    logic                   w_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
            r_clk_prev  <= w_clk_s;
        end
    end

    assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
    assign w_bit   = r_data_sync[SYNC_STAGES-1];
    assign w_fall  = r_clk_prev & ~w_clk_s;

    // ---------------- receive FSM ----------------
    rx_state_t              r_state,   w_state_n;
    logic [2:0]             r_bit_cnt, w_bit_cnt_n;
    logic [c_data_bits-1:0] r_shift,   w_shift_n;
    logic                   r_par,     w_par_n;
    logic [c_tw-1:0]        r_tmo,     w_tmo_n;
    logic                   r_wr_en,   w_wr_n;
    logic                   r_perr,    w_perr_n;
    logic                   r_ferr,    w_ferr_n;
    logic                   r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_tmo     <= '0;
            r_wr_en   <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_bit_cnt <= w_bit_cnt_n;
            r_shift   <= w_shift_n;
            r_par     <= w_par_n;
            r_tmo     <= w_tmo_n;
            r_wr_en   <= w_wr_n;
            r_perr    <= w_perr_n;
            r_ferr    <= w_ferr_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_bit_cnt_n = r_bit_cnt;
        w_shift_n   = r_shift;
        w_par_n     = r_par;
        w_tmo_n     = '0;
        w_wr_n      = 1'b0;
        w_perr_n    = 1'b0;
        w_ferr_n    = 1'b0;

        if (r_state != ST_IDLE) begin
            w_tmo_n = w_fall ? '0 : r_tmo + c_tw'(1);
        end

        case (r_state)
            ST_IDLE: begin
                if (w_fall && !w_bit) begin
                    w_state_n   = ST_DATA;
                    w_bit_cnt_n = '0;
                end
            end
            ST_DATA: begin
                if (w_fall) begin
                    w_shift_n   = {w_bit, r_shift[c_data_bits-1:1]};
                    w_bit_cnt_n = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'(c_data_bits - 1)) begin
                        w_state_n = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (w_fall) begin
                    w_par_n   = w_bit;
                    w_state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_fall) begin
                    w_state_n = ST_IDLE;
                    // A bad stop bit outranks a bad parity bit.
                    if (!w_bit) begin
                        w_ferr_n = 1'b1;
                    end else if (parity_good(r_shift, r_par)) begin
                        w_wr_n = 1'b1;
                    end else begin
                        w_perr_n = 1'b1;
                    end
                end
            end
            default: w_state_n = ST_IDLE;
        endcase

        if ((r_state != ST_IDLE) && !w_fall && (r_tmo == c_tmo_last)) begin
            w_state_n = ST_IDLE;
            w_ferr_n  = 1'b1;
        end
    end

    // ---------------- buffer ----------------
    // r_shift is stable in the write cycle: the FSM is back in IDLE, which never shifts.
    logic                   w_full;
    logic                   w_empty;
    logic [c_cw-1:0]        w_count;
    logic [c_data_bits-1:0] w_rd_data;

    ps2_byte_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (r_wr_en),
        .wr_data (r_shift),
        .rd_en   (bus.rd_en),
        .rd_data (w_rd_data),
        .empty   (w_empty),
        .full    (w_full),
        .count   (w_count)
    );

    // Setting wins over clearing so a coincident drop is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (r_wr_en && w_full && !bus.rd_en) begin
            r_ovf <= 1'b1;
        end else if (bus.clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    assign bus.rd_data    = w_rd_data;
    assign bus.empty      = w_empty;
    assign bus.count      = w_count;
    assign bus.overflow   = r_ovf;
    assign bus.parity_err = r_perr;
    assign bus.frame_err  = r_ferr;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_rx_fifo
// Description : Self-checking bench for ps2_rx_fifo (FIFO_DEPTH=4,
//               TIMEOUT_CYCLES=100). A queue-based model tracks the expected
//               buffer contents, overflow flag and error pulses; it is compared
//               with the DUT every cycle, alongside literal scenario checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_rx_fifo;
    localparam int DEPTH = 4;
    localparam int TMO   = 100;
    localparam int SYNC  = 2;
    localparam int HALF  = 10;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic ps2_clk  = 1'b1;
    logic ps2_data = 1'b1;

    always #5 clk = ~clk;

    ps2_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

    ps2_rx_fifo #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .bus      (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    int         cyc      = 0;
    logic [7:0] q[$];
    bit         m_ovf    = 1'b0;
    int         wr_at    = -1;
    int         perr_at  = -1;
    int         ferr_at  = -1;
    logic [7:0] wr_byte  = 8'h00;
    bit         exp_perr = 1'b0;
    bit         exp_ferr = 1'b0;
    bit         m_rd_ok;
    bit         m_ovf_new;

    always @(posedge clk or negedge rst_n) begin
        cyc++;
        if (!rst_n) begin
            q.delete();
            m_ovf    = 1'b0;
            exp_perr = 1'b0;
            exp_ferr = 1'b0;
            wr_at    = -1;
            perr_at  = -1;
            ferr_at  = -1;
        end else begin
            exp_perr  = (cyc == perr_at);
            exp_ferr  = (cyc == ferr_at);
            m_ovf_new = 1'b0;
            m_rd_ok   = bus.rd_en && (q.size() > 0);
            if (m_rd_ok) void'(q.pop_front());
            if (cyc == wr_at) begin
                if (q.size() < DEPTH) q.push_back(wr_byte);
                else m_ovf_new = 1'b1;
            end
            if (m_ovf_new) m_ovf = 1'b1;
            else if (bus.clr_ovf) m_ovf = 1'b0;
        end
    end

    // ---------------- per-cycle compare ----------------
    int perr_seen = 0;
    int ferr_seen = 0;
    int ferr_cyc  = -1;

    always @(posedge clk) begin
        #2;
        check("empty", bus.empty, (q.size() == 0));
        check("count", bus.count, q.size());
        check("overflow", bus.overflow, m_ovf);
        check("parity_err", bus.parity_err, exp_perr);
        check("frame_err", bus.frame_err, exp_ferr);
        if (!rst_n) check("rd_data_rst", bus.rd_data, 8'h00);
        else if (q.size() > 0) check("rd_data", bus.rd_data, q[0]);
        if (bus.parity_err) perr_seen++;
        if (bus.frame_err) begin
            ferr_seen++;
            ferr_cyc = cyc;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_bit(input logic b, output int k);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        k = cyc;
    endtask

    task automatic release_clk();
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    // Full frame; outcome scheduled from the frame rules at the stop edge.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        logic [10:0] f;
        int k;
        int det;
        f = {stop, par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            drive_bit(f[i], k);
            if (i == 10) begin
                det = k + SYNC;
                if (!stop) ferr_at = det + 1;
                else if (^{d, par}) begin
                    wr_byte = d;
                    wr_at   = det + 2;
                end else perr_at = det + 1;
            end
            release_clk();
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_partial(input logic [7:0] d, input int nbits, output int last_k);
        logic [8:0] f;
        int k;
        f = {d, 1'b0};
        for (int i = 0; i <= nbits; i++) begin
            drive_bit(f[i], k);
            release_clk();
        end
        last_k   = k;
        ps2_data = 1'b1;
    endtask

    task automatic pop_expect(input logic [7:0] exp);
        @(negedge clk);
        check("pop_data", bus.rd_data, exp);
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    int p0, f0, k_last, n_wait;

    initial begin
        bus.rd_en   = 1'b0;
        bus.clr_ovf = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_empty", bus.empty, 1'b1);
        check("rst_count", bus.count, 0);
        check("rst_rd_data", bus.rd_data, 8'h00);
        check("rst_overflow", bus.overflow, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Good frame 0x1C (three ones, parity 0)
        p0 = perr_seen; f0 = ferr_seen;
        send_frame(8'h1C, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        check("s1_empty", bus.empty, 1'b0);
        check("s1_rd_data", bus.rd_data, 8'h1C);
        check("s1_count", bus.count, 1);
        check("s1_no_err", (perr_seen - p0) + (ferr_seen - f0), 0);
        pop_expect(8'h1C);

        // Bad parity
        p0 = perr_seen;
        send_frame(8'h1C, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        check("s2_perr_pulses", perr_seen - p0, 1);
        check("s2_empty", bus.empty, 1'b1);

        // Bad stop and bad parity: only frame_err
        p0 = perr_seen; f0 = ferr_seen;
        send_frame(8'h1C, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        check("s2b_ferr_pulses", ferr_seen - f0, 1);
        check("s2b_perr_pulses", perr_seen - p0, 0);

        // Overflow: five bytes into a 4-deep buffer
        for (int b = 1; b <= 5; b++) send_frame(8'(b), ~^(8'(b)), 1'b1);
        repeat (10) @(negedge clk);
        check("s3_count", bus.count, 4);
        check("s3_overflow", bus.overflow, 1'b1);
        for (int b = 1; b <= 4; b++) pop_expect(8'(b));
        @(negedge clk); bus.clr_ovf = 1'b1;
        @(negedge clk); bus.clr_ovf = 1'b0;
        check("s3_ovf_cleared", bus.overflow, 1'b0);

        // Full buffer, pop coincides with the fifth write
        for (int b = 1; b <= 4; b++) send_frame(8'(b), ~^(8'(b)), 1'b1);
        repeat (10) @(negedge clk);
        check("s4_full_count", bus.count, 4);
        fork
            send_frame(8'h05, ~^(8'h05), 1'b1);
            begin
                n_wait = 0;
                while ((cyc != wr_at - 1) && (n_wait < 600)) begin
                    @(negedge clk);
                    n_wait++;
                end
                check("s4_rd_align", (n_wait < 600), 1'b1);
                check("s4_head", bus.rd_data, 8'h01);
                bus.rd_en = 1'b1;
                @(negedge clk);
                bus.rd_en = 1'b0;
            end
        join
        repeat (10) @(negedge clk);
        check("s4_overflow", bus.overflow, 1'b0);
        check("s4_count", bus.count, 4);
        for (int b = 2; b <= 5; b++) pop_expect(8'(b));

        // Timeout after four data bits
        f0 = ferr_seen;
        send_partial(8'hA7, 4, k_last);
        ferr_at = k_last + SYNC + TMO;
        repeat (TMO + 20) @(negedge clk);
        check("s5_ferr_pulses", ferr_seen - f0, 1);
        check("s5_ferr_delay", ferr_cyc - k_last, 102);
        send_frame(8'hF0, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        check("s5_count", bus.count, 1);
        pop_expect(8'hF0);

        // Reset mid-frame
        p0 = perr_seen; f0 = ferr_seen;
        send_partial(8'hC3, 5, k_last);
        @(negedge clk); rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("s6_rst_count", bus.count, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h5A, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        check("s6_count", bus.count, 1);
        check("s6_rd_data", bus.rd_data, 8'h5A);
        check("s6_no_err", (perr_seen - p0) + (ferr_seen - f0), 0);
        pop_expect(8'h5A);
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, meaning receive-buffer depth in bytes; legal values are powers of two from 2 to 64.
REQ-002 Parameter TIMEOUT_CYCLES, default 20000, meaning the maximum number of clk cycles allowed between PS/2 falling edges inside a frame.
REQ-003 Parameter SYNC_STAGES, default 2, meaning flip-flop stages on ps2_clk/ps2_data; minimum 2.
REQ-004 clk  input  1  system clock; the only clock.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 ps2_clk  input  1  PS/2 clock from the device, asynchronous.
REQ-007 ps2_data  input  1  PS/2 data from the device, asynchronous.
REQ-008 rd_en  input  1  pops the head byte; ignored while empty.
REQ-009 clr_ovf  input  1  clears the sticky overflow flag.
REQ-010 rd_data  output  8  head byte (show-ahead); valid only while empty=0.
REQ-011 empty  output  1  FIFO holds no bytes.
REQ-012 count  output  $clog2(FIFO_DEPTH)+1  bytes currently held.
REQ-013 overflow  output  1  sticky flag: at least one good byte was dropped because the FIFO was full.
REQ-014 parity_err  output  1  one-cycle pulse: a frame was discarded for bad odd parity.
REQ-015 frame_err  output  1  one-cycle pulse: a frame was discarded for bad stop bit or timeout.

Function
REQ-016 ps2_clk and ps2_data shall each pass through SYNC_STAGES flops; a falling edge is synced-clk 1 then 0 on consecutive cycles.
REQ-017 Data shall be sampled from synced ps2_data in the cycle the falling edge is detected.
REQ-018 The receive FSM shall have states IDLE, DATA, PARITY, STOP.
REQ-019 IDLE -> DATA on a falling edge with data=0; a falling edge with data=1 in IDLE is ignored.
REQ-020 DATA shall shift in 8 bits LSB first, using a 3-bit counter; after the 8th bit -> PARITY.
REQ-021 PARITY samples one bit -> STOP; the parity is good when the XOR of the 8 data bits and the parity bit equals 1.
REQ-022 STOP samples one bit -> IDLE, always.
REQ-023 If stop=1 and parity is good, the byte shall be written to the FIFO in the cycle after the stop edge; empty=0 is visible one cycle later.
REQ-024 If stop=0, the byte shall be discarded and frame_err shall pulse; a bad stop takes precedence over a bad parity (only frame_err pulses).
REQ-025 If stop=1 and parity is bad, the byte shall be discarded and parity_err shall pulse.
REQ-026 In any non-IDLE state, a counter shall reset on each falling edge; when it reaches TIMEOUT_CYCLES, the FSM -> IDLE, the partial byte is discarded and frame_err pulses.
REQ-027 The timeout counter shall be held at 0 in IDLE.
REQ-028 A write to a full FIFO without a same-cycle read shall drop the byte and set overflow=1; count and contents are unchanged.
REQ-029 A write to a full FIFO with rd_en=1 in the same cycle shall perform both operations; count stays at FIFO_DEPTH and overflow is not set.
REQ-030 A simultaneous write and read on a non-empty, non-full FIFO shall leave count unchanged.
REQ-031 overflow shall stay 1 until a cycle with clr_ovf=1; if clr_ovf and a new overflow coincide, overflow stays 1.
REQ-032 Read and write pointers shall be log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
REQ-033 rd_data shall update in the cycle after a pop, or after the first write into an empty FIFO.

Reset
REQ-034 With rst_n=0: FSM=IDLE, pointers, count and timeout counter =0, synchronisers =1, empty=1, count=0, rd_data=8'h00, overflow=0, parity_err=0, frame_err=0.
REQ-035 A reset mid-frame shall discard the partial frame; no error pulse is generated on release.
REQ-036 Reset deassertion shall be synchronised to clk externally; the block uses rst_n directly on its async reset pins.

Structure
REQ-037 FSM state encodings and the PS/2 frame constants (data bits=8, odd parity) shall live in shared package ps2_pkg.
REQ-038 Buffering shall be the sub-module ps2_byte_fifo (parameter DEPTH; ports wr_en/wr_data/rd_en/rd_data/empty/full/count); frame receive logic stays in ps2_rx_fifo.

Verification
REQ-039 Scenario: send 0x1C with parity 0 and stop 1 -> empty falls, rd_data=0x1C, count=1, no error pulses.
REQ-040 Scenario: send 0x1C with parity 1 -> parity_err pulses once, empty stays 1.
REQ-041 Scenario: FIFO_DEPTH=4, send 5 valid bytes 0x01..0x05 with no reads -> count=4, overflow=1, pops return 0x01..0x04; clr_ovf -> overflow=0.
REQ-042 Scenario: FIFO full, assert rd_en in the same cycle as the 5th write -> overflow=0, count=4, pops return 0x02..0x05.
REQ-043 Scenario: TIMEOUT_CYCLES=100, stop ps2_clk after 4 data bits -> frame_err pulses 100 cycles after the last edge; a following good frame 0xF0 is received correctly.
REQ-044 Scenario: pull rst_n low after 5 data bits, release, then send 0x5A -> only 0x5A is queued, with no error pulses.
